// File: rtl/vregfile_stride_pkg.sv
// vregfile_stride_pkg: write-op encoding and next-value function shared by the write and bypass paths
package vregfile_stride_pkg;
  localparam int MAX_WIDTH = 64;
  typedef logic [MAX_WIDTH-1:0] word_t;
  typedef logic [1:0] op_t;
  localparam op_t OP_LOAD = 2'b10;
  localparam op_t OP_ACC  = 2'b11;
  // Callers widen to word_t and truncate back to WIDTH, so the sum wraps modulo 2^WIDTH.
  function automatic word_t next_val(input op_t op, input word_t old_val, input word_t data);
    return (op == OP_ACC) ? old_val + data : data;
  endfunction
endpackage

// File: rtl/vregfile_stride_rdport.sv
// vregfile_stride_rdport: one registered read port with out-of-range zeroing and optional write bypass
// Ports: clk, reset (async, active-high); rd_reg_i/rd_en_i read index/enable; regs_i storage view;
//        wr_en_i/wr_reg_i/wr_op_i/wr_data_i same-cycle write (only with VREGFILE_STRIDE_BYPASS_EN);
//        rd_data_o registered read data.
module vregfile_stride_rdport
  import vregfile_stride_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 8,
  parameter int LOG2NUMREGS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOG2NUMREGS-1:0] rd_reg_i,
  input  logic                   rd_en_i,
  input  logic [WIDTH-1:0]       regs_i [NUMREGS],
`ifdef VREGFILE_STRIDE_BYPASS_EN
  input  logic                   wr_en_i,
  input  logic [LOG2NUMREGS-1:0] wr_reg_i,
  input  op_t                    wr_op_i,
  input  logic [WIDTH-1:0]       wr_data_i,
`endif
  output logic [WIDTH-1:0]       rd_data_o
);
  logic             in_range;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;
  assign in_range = 32'(rd_reg_i) < NUMREGS;
  assign old_val  = in_range ? regs_i[rd_reg_i] : '0;
`ifdef VREGFILE_STRIDE_BYPASS_EN
  // wr_en_i is already range-qualified, so a hit implies an in-range read index.
  assign rd_d = (wr_en_i && wr_reg_i == rd_reg_i)
              ? WIDTH'(next_val(wr_op_i, word_t'(old_val), word_t'(wr_data_i)))
              : old_val;
`else
  assign rd_d = old_val;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else if (rd_en_i) rd_q <= rd_d;
  end
  assign rd_data_o = rd_q;
endmodule

// File: rtl/vregfile_stride_mp.sv
// vregfile_stride_mp: multi-read-port stride/base register file with load and accumulate writes
// Ports: clk, reset (async, active-high); a_reg/a_en/a_readdataout packed per read port;
//        c_reg/c_writedatain/c_we/c_acc write side; c_written per-register written-since-reset mask.
// Build option: VREGFILE_STRIDE_BYPASS_EN makes same-cycle reads return the value being written.
module vregfile_stride_mp
  import vregfile_stride_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 8,
  parameter int LOG2NUMREGS = 3,
  parameter int NUMRDPORTS  = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUMRDPORTS*LOG2NUMREGS-1:0] a_reg,
  input  logic [NUMRDPORTS-1:0]             a_en,
  output logic [NUMRDPORTS*WIDTH-1:0]       a_readdataout,
  input  logic [LOG2NUMREGS-1:0]            c_reg,
  input  logic [WIDTH-1:0]                  c_writedatain,
  input  logic                              c_we,
  input  logic                              c_acc,
  output logic [NUMREGS-1:0]                c_written
);
  logic [WIDTH-1:0]   regs_q [NUMREGS];
  logic [WIDTH-1:0]   regs_d [NUMREGS];
  logic [NUMREGS-1:0] written_q;
  logic [NUMREGS-1:0] written_d;
  op_t                op;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_val;
  assign op     = {c_we, c_acc};
  // Out-of-range write indices are dropped entirely.
  assign wr_en  = c_we && (32'(c_reg) < NUMREGS);
  assign wr_val = WIDTH'(next_val(op, word_t'(regs_q[c_reg]), word_t'(c_writedatain)));
  always_comb begin
    regs_d    = regs_q;
    written_d = written_q;
    if (wr_en) begin
      regs_d[c_reg]    = wr_val;
      written_d[c_reg] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      written_q <= '0;
    end else begin
      regs_q    <= regs_d;
      written_q <= written_d;
    end
  end
  assign c_written = written_q;
  genvar p;
  for (p = 0; p < NUMRDPORTS; p++) begin : g_rd
    vregfile_stride_rdport #(
      .WIDTH      (WIDTH),
      .NUMREGS    (NUMREGS),
      .LOG2NUMREGS(LOG2NUMREGS)
    ) u_rd (
      .clk      (clk),
      .reset    (reset),
      .rd_reg_i (a_reg[p*LOG2NUMREGS +: LOG2NUMREGS]),
      .rd_en_i  (a_en[p]),
      .regs_i   (regs_q),
`ifdef VREGFILE_STRIDE_BYPASS_EN
      .wr_en_i  (wr_en),
      .wr_reg_i (c_reg),
      .wr_op_i  (op),
      .wr_data_i(c_writedatain),
`endif
      .rd_data_o(a_readdataout[p*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_vregfile_stride_mp.sv
// tb_vregfile_stride_mp: randomized and directed check of vregfile_stride_mp against an array model
module tb_vregfile_stride_mp;
  localparam int W  = 32;
  localparam int NR = 6;
  localparam int L  = 3;
  localparam int NP = 2;
`ifdef VREGFILE_STRIDE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NP*L-1:0] a_reg = '0;
  logic [NP-1:0]   a_en = '0;
  logic [NP*W-1:0] a_readdataout;
  logic [L-1:0]    c_reg = '0;
  logic [W-1:0]    c_writedatain = '0;
  logic            c_we = 1'b0;
  logic            c_acc = 1'b0;
  logic [NR-1:0]   c_written;
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_reg [8];
  logic [7:0]   m_wr;
  logic [W-1:0] m_out [NP];
  vregfile_stride_mp #(.WIDTH(W), .NUMREGS(NR), .LOG2NUMREGS(L), .NUMRDPORTS(NP)) dut (
    .clk(clk), .reset(reset), .a_reg(a_reg), .a_en(a_en), .a_readdataout(a_readdataout),
    .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we), .c_acc(c_acc), .c_written(c_written)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag);
    for (int p = 0; p < NP; p++) check($sformatf("%s.port%0d", tag, p), 64'(a_readdataout[p*W +: W]), 64'(m_out[p]));
    check({tag, ".written"}, 64'(c_written), 64'(m_wr[NR-1:0]));
  endtask
  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_wr = '0;
    for (int p = 0; p < NP; p++) m_out[p] = '0;
  endtask
  // Called at a falling edge: asserts reset between edges and checks the asynchronous clear.
  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_clear();
    check_all(tag);
    @(negedge clk) reset = 1'b0;
  endtask
  // Called at a falling edge: drives one cycle, advances the model, checks after the rising edge.
  task automatic step(input string tag, input bit we, input bit acc, input int wr, input logic [W-1:0] d,
                      input logic [1:0] en, input int r0, input int r1);
    logic [W-1:0] nv;
    int ra [NP];
    ra[0] = r0;
    ra[1] = r1;
    c_we = we; c_acc = acc; c_reg = L'(wr); c_writedatain = d;
    a_en = en; a_reg = {L'(r1), L'(r0)};
    nv = acc ? m_reg[wr] + d : d;
    for (int p = 0; p < NP; p++)
      if (en[p]) m_out[p] = (ra[p] >= NR) ? '0 : (BYPASS && we && wr == ra[p]) ? nv : m_reg[ra[p]];
    if (we && wr < NR) begin
      m_reg[wr] = nv;
      m_wr[wr] = 1'b1;
    end
    @(posedge clk);
    #1 check_all(tag);
    @(negedge clk);
  endtask
  initial begin
    model_clear();
    @(negedge clk);
    do_reset("por");
    step("ld3", 1, 0, 3, 32'h55, 2'b00, 0, 0);
    step("rd3", 0, 0, 0, 0, 2'b01, 3, 3);
    do_reset("midrst");
    step("rd3_after_rst", 0, 0, 0, 0, 2'b11, 3, 3);
    step("ld2", 1, 0, 2, 32'h100, 2'b00, 0, 0);
    step("acc2a", 1, 1, 2, 32'h20, 2'b00, 0, 0);
    step("acc2b", 1, 1, 2, 32'h20, 2'b00, 0, 0);
    step("rd2", 0, 0, 0, 0, 2'b01, 2, 0);
    check("acc_result", 64'(a_readdataout[W-1:0]), 64'h140);
    step("ld1", 1, 0, 1, 32'hFFFF_FFF0, 2'b00, 0, 0);
    step("wrap1", 1, 1, 1, 32'h20, 2'b00, 0, 0);
    step("rdwrap", 0, 0, 0, 0, 2'b01, 1, 0);
    step("neg1", 1, 1, 1, 32'hFFFF_FFFC, 2'b00, 0, 0);
    step("rdneg", 0, 0, 0, 0, 2'b10, 0, 1);
    step("ld4", 1, 0, 4, 32'h7, 2'b00, 0, 0);
    step("rdw4", 1, 1, 4, 32'h1, 2'b11, 4, 4);
    check("rdw_port0", 64'(a_readdataout[W-1:0]), BYPASS ? 64'h8 : 64'h7);
    step("rdw4_next", 0, 0, 0, 0, 2'b11, 4, 4);
    step("ld0", 1, 0, 0, 32'hA, 2'b00, 0, 0);
    step("rd0_p1", 0, 0, 0, 0, 2'b10, 0, 0);
    step("hold_ld", 1, 0, 0, 32'hB, 2'b00, 0, 0);
    step("hold", 0, 0, 0, 0, 2'b00, 0, 0);
    step("reen", 0, 0, 0, 0, 2'b10, 0, 0);
    step("oor_wr", 1, 0, 7, 32'hDEAD, 2'b00, 0, 0);
    step("oor_acc", 1, 1, 6, 32'h1, 2'b00, 0, 0);
    step("oor_rd", 0, 0, 0, 0, 2'b11, 6, 7);
    for (int i = 0; i < 400; i++) begin
      int wr, r0, r1;
      logic [W-1:0] d;
      wr = $urandom_range(0, 7);
      r0 = $urandom_range(0, 3) == 0 ? wr : $urandom_range(0, 7);
      r1 = $urandom_range(0, 3) == 0 ? r0 : $urandom_range(0, 7);
      d  = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 64));
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wr, d, 2'($urandom_range(0, 3)), r0, r1);
      if ($urandom_range(0, 60) == 0) do_reset("rand_rst");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
